// File: rtl/serial_add_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder/subtractor with a valid/ready handshake.
//               A single 1-bit full adder is reused once per bit, LSB first.
//               The result is available WIDTH cycles after acceptance and is
//               held until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0]    c_idle = 2'd0;
  localparam logic [1:0]    c_run  = 2'd1;
  localparam logic [1:0]    c_done = 2'd2;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic w_x;
  logic w_y;
  logic w_s;
  logic w_c;
  logic w_accept;

  // Shared full adder: the subtrahend is inverted and the carry seeded with 1
  // for subtraction, so a-b is computed as a + ~b + 1.
  assign w_x = r_a[r_cnt];
  assign w_y = r_b[r_cnt] ^ r_sub;
  assign w_s = w_x ^ w_y ^ r_carry;
  assign w_c = (w_x & w_y) | (w_x & r_carry) | (w_y & r_carry);

  assign w_accept  = (r_state == c_idle) && in_valid;

  assign in_ready  = (r_state == c_idle);
  assign out_valid = (r_state == c_done);
  assign busy      = (r_state != c_idle);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  // Control FSM: accept in IDLE, WIDTH serial steps in RUN, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_state <= c_run;
            r_cnt   <= '0;
          end
        end
        c_run: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= c_done;
          end
        end
        c_done: begin
          if (out_ready) begin
            r_state <= c_idle;
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  // Datapath: latch operands on accept, then shift one result bit per cycle
  // into the MSB; flags are captured from the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sub   <= sub;
      r_carry <= sub;
    end else if (r_state == c_run) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_c;
      if (r_cnt == c_last) begin
        r_cout <= w_c;
        r_ovf  <= r_carry ^ w_c;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (WIDTH = 8) using
//               directed vectors and a random back-to-back stream compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int tests;
  int fails;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from integer arithmetic.
  function automatic logic [9:0] ref_model(input logic [7:0] x, input logic [7:0] y,
                                           input logic s);
    int ux, uy, sx, sy, ures, sres;
    logic c, v;
    logic [7:0] r;
    ux = int'(x);
    uy = int'(y);
    sx = (ux > 127) ? ux - 256 : ux;
    sy = (uy > 127) ? uy - 256 : uy;
    if (s) begin
      ures = ux - uy;
      sres = sx - sy;
      c    = (ux >= uy);
    end else begin
      ures = ux + uy;
      sres = sx + sy;
      c    = (ures > 255);
    end
    r = ures[7:0];
    v = (sres > 127) || (sres < -128);
    return {v, c, r};
  endfunction

  // Offer one operand set, scramble inputs after acceptance, wait for result.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                       output logic [7:0] rs, output logic rc, output logic ro,
                       output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a = 8'h12; b = 8'h34; sub = 1'b0;
    #3;
    tests++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b sum=%h c=%b v=%b, want rdy=1 vld=0 busy=0 sum=00 c=0 v=0",
               in_ready, out_valid, busy, sum, cout, ovf);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_no_accept: got busy=%b rdy=%b, want busy=0 rdy=1", busy, in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] va [5], vb [5], es [5];
    logic       vs [5], ec [5], ev [5];
    logic [7:0] rs;
    logic       rc, ro;
    int         lat;
    va = '{8'hFF, 8'h05, 8'h03, 8'h7F, 8'h80};
    vb = '{8'h01, 8'h03, 8'h05, 8'h01, 8'h01};
    vs = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    es = '{8'h00, 8'h02, 8'hFE, 8'h80, 8'h7F};
    ec = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
    ev = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vs[i], rs, rc, ro, lat);
      tests++;
      if (lat !== WIDTH) begin
        fails++;
        $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, WIDTH);
      end
      tests++;
      if ({rs, rc, ro} !== {es[i], ec[i], ev[i]}) begin
        fails++;
        $display("FAIL directed_result[%0d]: got sum=%h c=%b v=%b, want sum=%h c=%b v=%b",
                 i, rs, rc, ro, es[i], ec[i], ev[i]);
      end
      take_result();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL directed_release[%0d]: got vld=%b rdy=%b, want vld=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] rs;
    logic       rc, ro;
    int         lat;
    logic [9:0] exp;
    logic [7:0] ta, tb_v;
    logic       ts;
    ta = 8'($urandom); tb_v = 8'($urandom); ts = 1'($urandom);
    exp = ref_model(ta, tb_v, ts);
    do_op(ta, tb_v, ts, rs, rc, ro, lat);
    tests++;
    if ({ro, rc, rs} !== exp) begin
      fails++;
      $display("FAIL hold_result: got %h, want %h", {ro, rc, rs}, exp);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      tests++;
      if ({ovf, cout, sum} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL hold_stable[%0d]: got res=%h rdy=%b vld=%b, want res=%h rdy=0 vld=1",
                 i, {ovf, cout, sum}, in_ready, out_valid, exp);
      end
    end
    in_valid = 1'b0;
    take_result();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: got vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_early_ready();
    logic [7:0] rs;
    logic       rc, ro;
    int         lat;
    logic [9:0] exp;
    exp = ref_model(8'h9C, 8'hA5, 1'b0);
    out_ready = 1'b1;
    do_op(8'h9C, 8'hA5, 1'b0, rs, rc, ro, lat);
    tests++;
    if (lat !== WIDTH || {ro, rc, rs} !== exp) begin
      fails++;
      $display("FAIL early_ready: got lat=%0d res=%h, want lat=%0d res=%h", lat, {ro, rc, rs}, WIDTH, exp);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL early_ready_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] rs;
    logic       rc, ro;
    int         lat;
    logic [9:0] exp;
    a = 8'hFF; b = 8'hFF; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL async_pre_busy: got %b, want 1", busy);
    end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_clear: got rdy=%b vld=%b busy=%b sum=%h c=%b v=%b, want 1 0 0 00 0 0",
               in_ready, out_valid, busy, sum, cout, ovf);
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL async_no_accept: got busy=%b, want 0", busy);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp = ref_model(8'h3C, 8'h5A, 1'b1);
    do_op(8'h3C, 8'h5A, 1'b1, rs, rc, ro, lat);
    tests++;
    if (lat !== WIDTH || {ro, rc, rs} !== exp) begin
      fails++;
      $display("FAIL async_after: got lat=%0d res=%h, want lat=%0d res=%h", lat, {ro, rc, rs}, WIDTH, exp);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic [9:0] q [$];
    logic [9:0] exp;
    int cyc, last, nacc;
    cyc = 0; last = -1; nacc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    while ((nacc < 1000 || q.size() > 0) && cyc < 20000) begin
      if (out_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL b2b_spurious: got out_valid=1 at cycle %0d, want no pending result", cyc);
        end else begin
          exp = q.pop_front();
          if ({ovf, cout, sum} !== exp) begin
            fails++;
            $display("FAIL b2b_result: got %h, want %h at cycle %0d", {ovf, cout, sum}, exp, cyc);
          end
        end
      end
      if (in_ready && nacc < 1000) begin
        if (last >= 0) begin
          tests++;
          if (cyc - last !== WIDTH + 2) begin
            fails++;
            $display("FAIL b2b_gap: got %0d cycles between accepts, want %0d", cyc - last, WIDTH + 2);
          end
        end
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        q.push_back(ref_model(a, b, sub));
        nacc++;
        last = cyc;
      end else begin
        in_valid = (nacc < 1000);
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (cyc >= 20000) begin
      fails++;
      $display("FAIL b2b_timeout: got %0d accepts and %0d pending, want 1000 and 0", nacc, q.size());
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_hold();
    test_early_ready();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation time limit, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
